// File: rtl/fluid_sample_ring_writer.sv
// Purpose: writes 16-bit samples into a shared-memory ring and publishes the head index after each one.
// Latency: a sample accepted in cycle N is written to RAM in N+1 and its head word in N+2 (one more of each with timestamps).
// Backpressure: in_ready is high only while idle and enabled; a sample offered while the ring is full is dropped and counted.
// Optional feature: define FLUID_RING_TIMESTAMP_EN to store a 16-bit cycle stamp word ahead of each sample.
module fluid_sample_ring_writer #(
    parameter logic [13:0] BASE_ADDR  = 14'h2000,
    parameter int          RING_WORDS = 1024,
    parameter logic [13:0] HEAD_ADDR  = 14'h1FFF,
    localparam int         IW         = $clog2(RING_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    input  logic [IW-1:0] tail_idx,
    output logic [13:0]   mem_address,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic          mem_clken,
    output logic [1:0]    mem_byteenable,
    output logic [15:0]   mem_writedata,
    output logic [IW-1:0] head_idx,
    output logic          full,
    output logic          empty,
    output logic [15:0]   drop_count
);

`ifdef FLUID_RING_TIMESTAMP_EN
    localparam int WPS = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, WR_TS = 2'd1, WR_DATA = 2'd2, WR_HEAD = 2'd3} state_t;
    logic [15:0] ts_cnt;
    logic [15:0] ts_q;
`else
    localparam int WPS = 1;
    typedef enum logic [1:0] {IDLE = 2'd0, WR_DATA = 2'd2, WR_HEAD = 2'd3} state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] tail_q;
    logic [IW-1:0] tail_eff;
    logic [IW-1:0] space;
    logic [15:0]   sample_q;
    logic          has_room;
    logic          xfer;

    // Tail is only trusted from the consumer while idle; during a sequence the copy taken at IDLE is used.
    assign tail_eff = (state == IDLE) ? tail_idx : tail_q;
    assign space    = tail_eff - head_idx - IW'(1);
    assign has_room = (space >= IW'(WPS));
    assign full     = !reset && !has_room;
    assign empty    = (head_idx == tail_eff);
    assign in_ready = (state == IDLE) && enable && !reset;
    assign xfer     = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and memory-port decode; memory port is idle (all zero) outside write states.
    always_comb begin
        state_nxt      = state;
        mem_address    = 14'd0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_clken      = 1'b0;
        mem_byteenable = 2'b00;
        mem_writedata  = 16'd0;
        case (state)
            IDLE: begin
                if (xfer && has_room) begin
`ifdef FLUID_RING_TIMESTAMP_EN
                    state_nxt = WR_TS;
`else
                    state_nxt = WR_DATA;
`endif
                end
            end
`ifdef FLUID_RING_TIMESTAMP_EN
            WR_TS: begin
                mem_address    = BASE_ADDR + 14'(head_idx);
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_clken      = 1'b1;
                mem_byteenable = 2'b11;
                mem_writedata  = ts_q;
                state_nxt      = WR_DATA;
            end
`endif
            WR_DATA: begin
                mem_address    = BASE_ADDR + 14'(head_idx);
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_clken      = 1'b1;
                mem_byteenable = 2'b11;
                mem_writedata  = sample_q;
                state_nxt      = WR_HEAD;
            end
            WR_HEAD: begin
                mem_address    = HEAD_ADDR;
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_clken      = 1'b1;
                mem_byteenable = 2'b11;
                mem_writedata  = 16'(head_idx);
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Head advance, sample latch, tail snapshot and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_idx   <= '0;
            tail_q     <= '0;
            sample_q   <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            if (state == IDLE) tail_q <= tail_idx;
            if (xfer) begin
                if (has_room)                    sample_q   <= in_data;
                else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
`ifdef FLUID_RING_TIMESTAMP_EN
            if (state == WR_TS || state == WR_DATA) head_idx <= head_idx + IW'(1);
`else
            if (state == WR_DATA) head_idx <= head_idx + IW'(1);
`endif
        end
    end

`ifdef FLUID_RING_TIMESTAMP_EN
    // Free-running cycle stamp, captured at the moment a sample is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= 16'd0;
            ts_q   <= 16'd0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (xfer && has_room) ts_q <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_fluid_sample_ring_writer.sv
// Purpose: randomized and directed checking of the ring writer against a transaction-level ring model.
// Latency: model schedules one expected memory operation per cycle after each accepted sample.
// Backpressure: model predicts in_ready and drops from ring occupancy.
module tb_fluid_sample_ring_writer;
    localparam int N  = 1024;
    localparam int IW = 10;
`ifdef FLUID_RING_TIMESTAMP_EN
    localparam int WPS = 2;
`else
    localparam int WPS = 1;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, in_valid, in_ready;
    logic [15:0]   in_data;
    logic [IW-1:0] tail_idx;
    logic [13:0]   mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [1:0]    mem_byteenable;
    logic [15:0]   mem_writedata;
    logic [IW-1:0] head_idx;
    logic          full, empty;
    logic [15:0]   drop_count;

    fluid_sample_ring_writer dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tail_idx(tail_idx),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .head_idx(head_idx), .full(full), .empty(empty), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic [15:0] data;
        int          head;
    } op_t;

    op_t         q[$];
    int          m_head, m_drop, m_tail_saved, m_ts;
    int          checks, errors, wr_count;
    logic [15:0] ram [0:16383];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ring_space(input int t, input int h);
        return (((t - h - 1) % N) + N) % N;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model at negedge, advance the model.
    task automatic cyc(input bit rst, input bit en, input bit vld, input logic [15:0] d, input int tl);
        logic [34:0] em;
        logic [34:0] gm;
        bit          busy;
        int          vis_head, t_eff, hn;
        reset = rst; enable = en; in_valid = vld; in_data = d; tail_idx = IW'(tl);
        @(negedge clk);
        gm = {mem_chipselect, mem_write, mem_clken, mem_byteenable, mem_address, mem_writedata};
        if (mem_write && mem_chipselect && mem_clken) begin
            ram[mem_address] = mem_writedata;
            wr_count++;
        end
        if (rst) begin
            q.delete();
            m_head = 0; m_drop = 0; m_ts = 0;
            chk("rst_mem", 64'(gm), 64'd0);
            chk("rst_ready", 64'(in_ready), 64'd0);
            chk("rst_full", 64'(full), 64'd0);
            chk("rst_empty", 64'(empty), 64'(tl % N == 0));
            chk("rst_head", 64'(head_idx), 64'd0);
            chk("rst_drop", 64'(drop_count), 64'd0);
        end else begin
            busy     = (q.size() > 0);
            em       = busy ? {3'b111, 2'b11, q[0].addr, q[0].data} : 35'd0;
            vis_head = busy ? q[0].head : m_head;
            t_eff    = busy ? m_tail_saved : tl;
            chk("mem", 64'(gm), 64'(em));
            chk("ready", 64'(in_ready), 64'(!busy && en));
            chk("head", 64'(head_idx), 64'(vis_head));
            chk("empty", 64'(empty), 64'(vis_head == t_eff));
            chk("full", 64'(full), 64'(ring_space(t_eff, vis_head) < WPS));
            chk("drop", 64'(drop_count), 64'(m_drop));
            if (busy) begin
                void'(q.pop_front());
            end else if (en && vld) begin
                if (ring_space(tl, m_head) >= WPS) begin
                    hn = m_head;
`ifdef FLUID_RING_TIMESTAMP_EN
                    q.push_back('{addr: 14'(14'h2000 + hn), data: 16'(m_ts), head: hn});
                    hn = (hn + 1) % N;
`endif
                    q.push_back('{addr: 14'(14'h2000 + hn), data: d, head: hn});
                    hn = (hn + 1) % N;
                    q.push_back('{addr: 14'h1FFF, data: 16'(hn), head: hn});
                    m_head = hn;
                    m_tail_saved = tl;
                end else if (m_drop < 16'hFFFF) begin
                    m_drop++;
                end
            end
            m_ts = (m_ts + 1) % 65536;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input int tl);
        cyc(0, 1, 1, d, tl);
        for (int i = 0; i < WPS + 1; i++) cyc(0, 1, 0, 16'd0, tl);
    endtask

    int w0, guard, rtail;

    initial begin
        checks = 0; errors = 0; wr_count = 0;
        m_head = 0; m_drop = 0; m_tail_saved = 0; m_ts = 0;
        cyc(1, 0, 0, 16'd0, 0);
        cyc(1, 0, 0, 16'd0, 0);

`ifndef FLUID_RING_TIMESTAMP_EN
        // Single sample into an empty ring.
        send(16'hA5A5, 0);
        chk("r33_ram", 64'(ram[14'h2000]), 64'h A5A5);
        chk("r33_headword", 64'(ram[14'h1FFF]), 64'h0001);
        chk("r33_head", 64'(head_idx), 64'd1);
        chk("r33_empty", 64'(empty), 64'd0);

        // Bring head to 4, then offer a sample with tail at 5 (ring full).
        for (int i = 0; i < 3; i++) send(16'(16'h0100 + i), 0);
        w0 = wr_count;
        send(16'h3333, 5);
        chk("r34_drop", 64'(drop_count), 64'd1);
        chk("r34_head", 64'(head_idx), 64'd4);
        chk("r34_nowrite", 64'(wr_count), 64'(w0));

        // Fill to head 1023, then write across the wrap point.
        guard = 0;
        while ((m_head != 1023 || q.size() != 0) && guard < 5000) begin
            cyc(0, 1, 1, 16'($urandom), 0);
            guard++;
        end
        chk("r35_reach", 64'(guard < 5000), 64'd1);
        send(16'h1111, 10);
        send(16'h2222, 10);
        chk("r35_last", 64'(ram[14'h23FF]), 64'h1111);
        chk("r35_wrap", 64'(ram[14'h2000]), 64'h2222);
        chk("r35_headword", 64'(ram[14'h1FFF]), 64'h0001);
        chk("r35_head", 64'(head_idx), 64'd1);
`else
        // Stamp captured at cycle counter 0x0010.
        guard = 0;
        while (m_ts != 16 && guard < 100) begin
            cyc(0, 1, 0, 16'd0, 0);
            guard++;
        end
        send(16'h7777, 0);
        chk("r37_ts", 64'(ram[14'h2000]), 64'h0010);
        chk("r37_data", 64'(ram[14'h2001]), 64'h7777);
        chk("r37_headword", 64'(ram[14'h1FFF]), 64'h0002);
`endif

        // Enable dropped right after acceptance: sequence still completes.
        w0 = wr_count;
        cyc(0, 1, 1, 16'h5A5A, 0);
        for (int i = 0; i < WPS + 2; i++) cyc(0, 0, 0, 16'd0, 0);
        chk("r38_writes", 64'(wr_count), 64'(w0 + WPS + 1));
        chk("r38_ready", 64'(in_ready), 64'd0);

        // Reset during the first write cycle aborts the sequence.
        w0 = wr_count;
        cyc(0, 1, 1, 16'hBEEF, 0);
        cyc(1, 1, 0, 16'd0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'd0, 0);
        chk("r36_nowrite", 64'(wr_count), 64'(w0));
        chk("r36_head", 64'(head_idx), 64'd0);

        // Randomized traffic with moving consumer index and occasional resets.
        rtail = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) rtail = $urandom_range(0, N - 1);
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 3) != 0), 16'($urandom), rtail);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
